activation_writer_bram: RTL and testbench
=========================================

Name: activation_writer_bram

Overview:
- Reverse counterpart of the layer weight loaders.
- Takes a flat packed vector of W-bit elements, e.g. a layer's output activations, and streams it into the shared single-port BRAM, one element per cycle, starting at a run-time base address.
- Drives the BRAM port signals directly. The top level muxes these with the loaders' BRAM port.
- Element packing matches the loaders: element i = data_in[i*W +: W]. A write followed by a loader read at the same base round-trips the vector.

Parameters:
- NUM_ELEMS, 8, number of elements in data_in.
- W, 8, element width in bits; equals the BRAM data width.
- ADDR_WIDTH, 18, BRAM address width.
- LEN_WIDTH, $clog2(NUM_ELEMS+1), width of the length input.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin a write burst; sampled only in IDLE.
- data_in  input  NUM_ELEMS*W  packed elements; snapshot taken when start is accepted.
- base_addr  input  ADDR_WIDTH  BRAM address for element 0; latched when start is accepted.
- length  input  LEN_WIDTH  number of elements to write; latched when start is accepted.
- bram_en  output  1  BRAM enable.
- bram_wen  output  1  BRAM write enable.
- bram_addr  output  ADDR_WIDTH  BRAM address.
- bram_din  output  W  BRAM write data.
- busy  output  1  high in WRITE and DONE.
- done  output  1  one-cycle pulse on burst completion.

Behaviour:
- All outputs are registered.
- Reset values: bram_en=0, bram_wen=0, bram_addr=0, bram_din=0, busy=0, done=0, state=IDLE.
- Reset is asynchronous: asserting rst_n low forces the reset values immediately.
- States: IDLE, WRITE, DONE.
- IDLE:
  - On a clk edge with start=1, latch data_in into snapshot register buf, latch base_addr into addr_q, and latch the effective length into len_q.
  - Effective length = min(length, NUM_ELEMS).
  - Clear index i to 0.
  - Go to WRITE if len_q>0, otherwise go straight to DONE.
- WRITE:
  - Each cycle present bram_en=1, bram_wen=1, bram_addr=addr_q+i (modulo 2^ADDR_WIDTH, wraps silently) and bram_din=buf[i*W +: W].
  - Increment i each cycle.
  - After element len_q-1 has been presented, go to DONE.
- DONE:
  - For exactly one cycle: done=1, bram_en=0, bram_wen=0.
  - Next cycle return to IDLE.
- Latency: if start is sampled at edge 0, element k is presented during the cycle after edge k+1 and written by the BRAM at edge k+2. done is high during the cycle after edge len_q+1. For len_q=0, done is high during the cycle after edge 1.
- busy=1 whenever state is WRITE or DONE.
- start while busy is ignored; no queueing.
- Changes to data_in, base_addr or length after acceptance have no effect on the burst in progress.
- start held high continuously: a new burst is accepted on the first IDLE edge after DONE, giving back-to-back bursts with one IDLE cycle between them.
- Reset mid-burst: the burst is aborted and the outputs return to their reset values asynchronously. Elements already written stay in the BRAM. No done pulse is issued.
- bram_addr and bram_din keep their last values while bram_en=0. Benches must check them only when bram_en=1.

Decomposition:
- Shared package (e.g. nn_bram_pkg): BRAM data width (8), BRAM address width (18), the writer state encoding (IDLE/WRITE/DONE), and layer base-address constants, including 64512 for the layer1 weights region.
- Loaders and writer both import this package.
- No sub-module: the single FSM plus datapath is small. The BRAM instance stays at the top level behind the port mux.

Test Plan:
- Full burst: base_addr=64512, length=8, data_in=0x0807060504030201. Expect writes 0x01..0x08 to addresses 64512..64519 on 8 consecutive cycles, done high during the cycle after edge 9, busy low afterwards, and a read-back of those addresses returning the same bytes.
- Partial and clamped lengths: length=3 gives exactly 3 writes (addresses base..base+2) with done at edge 4. length=15 with NUM_ELEMS=8 gives exactly 8 writes.
- Zero length: length=0 gives no cycle with bram_en=1, a done pulse one cycle after acceptance, and a return to IDLE.
- Address wrap: base_addr=262142, length=4. Expect writes to addresses 262142, 262143, 0, 1 in that order.
- Snapshot and ignore:
  - Change data_in and base_addr on the cycle after start: the written values and addresses use the originally latched inputs.
  - Pulse start during WRITE: no restart and no extra writes.
- Reset mid-burst:
  - Drive rst_n low between clock edges after 3 writes of an 8-element burst. bram_en, bram_wen and busy drop to 0 immediately, no done pulse occurs, and addresses base..base+2 keep their written data.
  - A fresh start after release completes normally.

Source files
------------

// File: rtl/activation_writer_bram_pkg.sv
// activation_writer_bram_pkg: shared BRAM geometry, writer state encoding and layer base addresses
package activation_writer_bram_pkg;
  localparam int BRAM_DW = 8;
  localparam int BRAM_AW = 18;
  localparam logic [BRAM_AW-1:0] L1_W_BASE = 18'd64512;
  localparam logic [BRAM_AW-1:0] L1_B_BASE = 18'd65024;
  localparam logic [BRAM_AW-1:0] L2_W_BASE = 18'd65536;
  localparam logic [BRAM_AW-1:0] ACT_BASE = 18'd131072;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_e;
endpackage

// File: rtl/activation_writer_bram.sv
// activation_writer_bram: streams a packed activation vector into the shared BRAM, one element per cycle
module activation_writer_bram
  import activation_writer_bram_pkg::*;
#(
  parameter int NUM_ELEMS  = 8,
  parameter int W          = BRAM_DW,
  parameter int ADDR_WIDTH = BRAM_AW,
  parameter int LEN_WIDTH  = $clog2(NUM_ELEMS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NUM_ELEMS*W-1:0]  data_in,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [LEN_WIDTH-1:0]    length,
  output logic                    bram_en,
  output logic                    bram_wen,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [W-1:0]            bram_din,
  output logic                    busy,
  output logic                    done
);
  wr_state_e state_q, state_d;
  logic [NUM_ELEMS*W-1:0] buf_q, buf_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0] len_q, len_d, idx_q, idx_d, len_eff;
  logic en_q, en_d, wen_q, wen_d, busy_q, busy_d, done_q, done_d;
  logic [ADDR_WIDTH-1:0] baddr_q, baddr_d;
  logic [W-1:0] din_q, din_d;
  assign len_eff = (length > LEN_WIDTH'(NUM_ELEMS)) ? LEN_WIDTH'(NUM_ELEMS) : length;
  // next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    len_d   = len_q;
    idx_d   = idx_q;
    en_d    = 1'b0;
    wen_d   = 1'b0;
    baddr_d = baddr_q;
    din_d   = din_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        buf_d   = data_in;
        addr_d  = base_addr;
        len_d   = len_eff;
        idx_d   = '0;
        state_d = (len_eff != '0) ? ST_WRITE : ST_DONE;
      end
      ST_WRITE: begin
        en_d    = 1'b1;
        wen_d   = 1'b1;
        baddr_d = addr_q + ADDR_WIDTH'(idx_q);
        din_d   = buf_q[idx_q*W +: W];
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == len_q - 1'b1) ? ST_DONE : ST_WRITE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end
  // state, burst context and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      wen_q   <= 1'b0;
      baddr_q <= '0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      wen_q   <= wen_d;
      baddr_q <= baddr_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign bram_en   = en_q;
  assign bram_wen  = wen_q;
  assign bram_addr = baddr_q;
  assign bram_din  = din_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_activation_writer_bram.sv
// tb_activation_writer_bram: random and directed bursts checked against a schedule-based model and a BRAM model
module tb_activation_writer_bram;
  import activation_writer_bram_pkg::*;
  localparam int N = 8;
  localparam int W = 8;
  localparam int AW = 18;
  localparam int LW = 4;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [N*W-1:0] data_in = '0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] length = '0;
  logic bram_en, bram_wen, busy, done;
  logic [AW-1:0] bram_addr;
  logic [W-1:0] bram_din;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  activation_writer_bram #(.NUM_ELEMS(N), .W(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in), .base_addr(base_addr),
    .length(length), .bram_en(bram_en), .bram_wen(bram_wen), .bram_addr(bram_addr),
    .bram_din(bram_din), .busy(busy), .done(done)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // schedule model: a burst accepted at edge c writes at edges c+1..c+len, done at c+len+1, next accept at c+len+2
  int edge_n = 0, acc_e = 0, acc_len = 0, free_at = 0;
  bit act = 1'b0;
  logic [AW-1:0] acc_base = '0;
  logic [N*W-1:0] acc_data = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act = 1'b0;
      free_at = 0;
    end else begin
      edge_n++;
      if (start && edge_n >= free_at) begin
        act = 1'b1;
        acc_e = edge_n;
        acc_len = (int'(length) > N) ? N : int'(length);
        acc_base = base_addr;
        acc_data = data_in;
        free_at = edge_n + acc_len + 2;
      end
    end
  end
  // per-cycle comparison of every output against the model
  int done_rel = -1;
  always @(posedge clk) begin
    int k;
    logic e_en, e_busy, e_done;
    logic [AW-1:0] ea;
    #1;
    k = edge_n - acc_e;
    e_en = act && k >= 1 && k <= acc_len;
    e_busy = act && k >= 0 && k <= acc_len;
    e_done = act && k == acc_len + 1;
    chk("bram_en", 64'(bram_en), 64'(e_en));
    chk("bram_wen", 64'(bram_wen), 64'(e_en));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    if (e_en) begin
      ea = acc_base + AW'(k - 1);
      chk("bram_addr", 64'(bram_addr), 64'(ea));
      chk("bram_din", 64'(bram_din), 64'(acc_data[(k-1)*W +: W]));
    end
    if (done) done_rel = k;
  end
  // BRAM model: capture the presented write mid-cycle, commit it at the next edge unless reset intervened
  logic [W-1:0] mem [logic [AW-1:0]];
  logic [AW-1:0] wq[$];
  logic pv = 1'b0;
  logic [AW-1:0] pa;
  logic [W-1:0] pd;
  always @(negedge clk) begin
    pv = bram_en && bram_wen;
    pa = bram_addr;
    pd = bram_din;
  end
  always @(posedge clk) begin
    if (pv && rst_n) begin
      mem[pa] = pd;
      wq.push_back(pa);
    end
  end
  function automatic logic [W-1:0] rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction
  task automatic wait_done();
    int t = 0;
    while (done !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask
  // mode 1 changes inputs right after acceptance; mode 2 pulses start mid-burst
  task automatic burst(input logic [AW-1:0] b, input int l, input logic [N*W-1:0] d, input int mode);
    wq.delete();
    done_rel = -1;
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    length = LW'(l);
    data_in = d;
    @(negedge clk);
    start = 1'b0;
    if (mode == 1) begin
      base_addr = ~b;
      data_in = ~d;
      length = LW'(N);
    end
    if (mode == 2) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
    @(negedge clk);
  endtask
  logic [AW-1:0] wrap_exp [4] = '{18'd262142, 18'd262143, 18'd0, 18'd1};
  initial begin
    logic [N*W-1:0] d;
    int t;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_en", 64'(bram_en), 64'd0);
    chk("rst_addr", 64'(bram_addr), 64'd0);
    chk("rst_din", 64'(bram_din), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    burst(L1_W_BASE, 8, 64'h0807060504030201, 0);
    chk("full_latency", 64'(done_rel), 64'd9);
    chk("full_count", 64'(wq.size()), 64'd8);
    chk("full_busy_after", 64'(busy), 64'd0);
    for (int i = 0; i < 8; i++) chk("full_readback", 64'(rd(L1_W_BASE + AW'(i))), 64'(i + 1));
    burst(18'd100, 3, {$urandom, $urandom}, 0);
    chk("len3_latency", 64'(done_rel), 64'd4);
    chk("len3_count", 64'(wq.size()), 64'd3);
    chk("len3_first", 64'(wq[0]), 64'd100);
    chk("len3_last", 64'(wq[2]), 64'd102);
    burst(18'd2000, 15, {$urandom, $urandom}, 0);
    chk("clamp_count", 64'(wq.size()), 64'd8);
    chk("clamp_latency", 64'(done_rel), 64'd9);
    burst(18'd3000, 0, {$urandom, $urandom}, 0);
    chk("zero_count", 64'(wq.size()), 64'd0);
    chk("zero_latency", 64'(done_rel), 64'd1);
    burst(18'd262142, 4, {$urandom, $urandom}, 0);
    chk("wrap_count", 64'(wq.size()), 64'd4);
    for (int i = 0; i < 4 && i < wq.size(); i++) chk("wrap_addr", 64'(wq[i]), 64'(wrap_exp[i]));
    d = 64'hA1B2C3D4E5F60718;
    burst(18'd5000, 8, d, 1);
    chk("snap_addr", 64'(wq[0]), 64'd5000);
    chk("snap_data", 64'(rd(18'd5000)), 64'h18);
    chk("snap_count", 64'(wq.size()), 64'd8);
    burst(18'd6000, 8, {$urandom, $urandom}, 2);
    chk("ignore_count", 64'(wq.size()), 64'd8);
    wq.delete();
    d = 64'h1122334455667788;
    @(negedge clk);
    start = 1'b1;
    base_addr = 18'd30000;
    length = LW'(8);
    data_in = d;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (wq.size() < 3 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reached", 64'(wq.size()), 64'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_en", 64'(bram_en), 64'd0);
    chk("abort_wen", 64'(bram_wen), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_count", 64'(wq.size()), 64'd3);
    for (int i = 0; i < 3; i++) chk("abort_keep", 64'(rd(18'd30000 + AW'(i))), 64'(d[i*W +: W]));
    chk("abort_no4th", 64'(mem.exists(18'd30003)), 64'd0);
    burst(18'd40000, 5, {$urandom, $urandom}, 0);
    chk("post_reset_count", 64'(wq.size()), 64'd5);
    @(negedge clk);
    start = 1'b1;
    base_addr = 18'd50000;
    length = LW'(2);
    data_in = {$urandom, $urandom};
    repeat (20) @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    for (int r = 0; r < 30; r++) begin
      burst(AW'($urandom), $urandom_range(0, 15), {$urandom, $urandom}, $urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
